cic_decim_pipelined: RTL and testbench

//  Parametrised N-stage CIC decimator with a runtime-selectable power-of-two ratio, input valid qualifier,

---
 rtl/cic_decim_pipelined.sv | 119 +++++++++++
 tb/tb_cic_decim_pipelined.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_pipelined.sv
// N-stage CIC decimator: valid-qualified integrators, power-of-two runtime ratio,
// valid-tagged comb pipeline, gain-boosted normalisation and output saturation.
module cic_decim_pipelined #(
   parameter int STAGES         = 5,
   parameter int INPUT_WIDTH    = 12,
   parameter int OUTPUT_WIDTH   = 12,
   parameter int MAX_DECIM_LOG2 = 14,
   parameter int GAIN_WIDTH     = 8,
   localparam int REG_WIDTH     = INPUT_WIDTH + STAGES*MAX_DECIM_LOG2,
   localparam int LW            = $clog2(MAX_DECIM_LOG2+1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic signed [INPUT_WIDTH-1:0]  data_in,
   input  logic        [LW-1:0]           decim_log2,
   input  logic        [GAIN_WIDTH-1:0]   gain,
   output logic                           out_valid,
   output logic signed [OUTPUT_WIDTH-1:0] data_out,
   output logic                           sat
);
   localparam int RW = REG_WIDTH;
   localparam logic [LW-1:0] LMAX = LW'(MAX_DECIM_LOG2);
   localparam logic signed [RW-1:0] OMAX = {{(RW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

   logic [LW-1:0]                 l_clamp, l_eff, l_q;
   logic                          load_q;
   logic [MAX_DECIM_LOG2-1:0]     cnt_q, last_cnt;
   logic                          bnd;
   logic [RW-1:0]                 x_ext, snap_q;
   logic [STAGES-1:0][RW-1:0]     integ_q, comb_q, dly_q, comb_in;
   logic [STAGES:0]               vld_pipe;
   logic [STAGES:0][LW-1:0]       lpipe_q;
   int                            sh_d;
   logic signed [RW-1:0]          y_d;
   logic signed [OUTPUT_WIDTH-1:0] data_d;
   logic                          sat_d;

   always_comb begin
      l_clamp = decim_log2;
      if (decim_log2 == '0)       l_clamp = LW'(1);
      else if (decim_log2 > LMAX) l_clamp = LMAX;
   end

   // load_q covers the first clock after reset, before l_q has captured the ratio
   assign l_eff    = load_q ? l_clamp : l_q;
   assign last_cnt = ~({MAX_DECIM_LOG2{1'b1}} << l_eff);
   assign bnd      = in_valid && (cnt_q == last_cnt);
   assign x_ext    = {{(RW-INPUT_WIDTH){data_in[INPUT_WIDTH-1]}}, data_in};

   always_comb begin
      comb_in[0] = snap_q;
      for (int k = 1; k < STAGES; k++) comb_in[k] = comb_q[k-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q   <= 1'b1;
         l_q      <= LW'(1);
         cnt_q    <= '0;
         integ_q  <= '0;
         snap_q   <= '0;
         comb_q   <= '0;
         dly_q    <= '0;
         vld_pipe <= '0;
         lpipe_q  <= '0;
      end else begin
         load_q <= 1'b0;
         if (load_q || bnd) l_q <= l_clamp;
         if (in_valid) begin
            integ_q[0] <= integ_q[0] + x_ext;
            for (int k = 1; k < STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
            cnt_q <= bnd ? '0 : cnt_q + MAX_DECIM_LOG2'(1);
         end
         if (bnd) snap_q <= integ_q[STAGES-1];
         // the launch-time ratio travels with the frame so scaling is immune to later changes
         vld_pipe[0] <= bnd;
         lpipe_q[0]  <= l_eff;
         for (int k = 0; k < STAGES; k++) begin
            vld_pipe[k+1] <= vld_pipe[k];
            lpipe_q[k+1]  <= lpipe_q[k];
            if (vld_pipe[k]) begin
               comb_q[k] <= comb_in[k] - dly_q[k];
               dly_q[k]  <= comb_in[k];
            end
         end
      end
   end

   always_comb begin
      sh_d = STAGES*int'(lpipe_q[STAGES]) + INPUT_WIDTH - OUTPUT_WIDTH - int'(gain);
      if (sh_d < 0) sh_d = 0;
      y_d    = $signed(comb_q[STAGES-1]) >>> sh_d;
      sat_d  = 1'b0;
      data_d = y_d[OUTPUT_WIDTH-1:0];
      if (y_d > OMAX) begin
         data_d = OMAX[OUTPUT_WIDTH-1:0];
         sat_d  = 1'b1;
      end else if (y_d < OMIN) begin
         data_d = OMIN[OUTPUT_WIDTH-1:0];
         sat_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         data_out  <= '0;
         sat       <= 1'b0;
      end else begin
         out_valid <= vld_pipe[STAGES];
         if (vld_pipe[STAGES]) begin
            data_out <= data_d;
            sat      <= sat_d;
         end
      end
   end
endmodule

// File: tb/tb_cic_decim_pipelined.sv
// Bench for cic_decim_pipelined: reference built from N-fold prefix sums of the accepted
// samples and an N-th binomial difference across frame snapshots.
module tb_cic_decim_pipelined;
   localparam int N = 5, IW = 12, OW = 12, MDL = 14, GW = 8, LW = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [IW-1:0] data_in = '0;
   logic [LW-1:0]        decim_log2 = 4'd4;
   logic [GW-1:0]        gain = '0;
   logic                 out_valid;
   logic signed [OW-1:0] data_out;
   logic                 sat;

   cic_decim_pipelined #(.STAGES(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                         .MAX_DECIM_LOG2(MDL), .GAIN_WIDTH(GW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
      .decim_log2(decim_log2), .gain(gain), .out_valid(out_valid),
      .data_out(data_out), .sat(sat));

   always #5 clk = ~clk;

   typedef logic signed [127:0] w_t;
   typedef struct { int due; logic signed [OW-1:0] d; logic s; } exp_t;

   exp_t expq[$];
   w_t   pn_hist[$];
   w_t   snaps[$];
   w_t   p[N+1];
   int   cnt_m, L_m, cyc;
   int   checks = 0, failures = 0;
   logic signed [OW-1:0] last_d = '0;
   logic last_s = 1'b0;

   function automatic int clampL(int d);
      return (d < 1) ? 1 : ((d > MDL) ? MDL : d);
   endfunction

   function automatic w_t binom(int n, int k);
      w_t r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      expq.delete(); pn_hist.delete(); snaps.delete();
      for (int k = 0; k <= N; k++) p[k] = 0;
      cnt_m = 0;
   endtask

   // One accepted sample: frame boundary check, then prefix-sum update
   task automatic accept(input logic signed [IW-1:0] d);
      int m, f, sh;
      w_t s, yf, term, y;
      logic signed [OW-1:0] dd;
      logic ss;
      m = pn_hist.size();
      if (cnt_m == (1 << L_m) - 1) begin
         s = (m >= N) ? pn_hist[m-N] : 0;
         snaps.push_back(s);
         f = snaps.size() - 1;
         yf = 0;
         for (int k = 0; k <= N; k++)
            if (f - k >= 0) begin
               term = binom(N, k) * snaps[f-k];
               yf = (k % 2) ? yf - term : yf + term;
            end
         sh = N*L_m + IW - OW - int'(gain);
         if (sh < 0) sh = 0;
         y = yf >>> sh;
         ss = 1'b1;
         if (y > 2047)       dd = 12'sd2047;
         else if (y < -2048) dd = -12'sd2048;
         else begin dd = y[OW-1:0]; ss = 1'b0; end
         expq.push_back('{cyc + N + 1, dd, ss});
         cnt_m = 0;
         L_m = clampL(int'(decim_log2));
      end else cnt_m++;
      p[1] = p[1] + d;
      for (int k = 2; k <= N; k++) p[k] = p[k] + p[k-1];
      pn_hist.push_back(p[N]);
   endtask

   task automatic tick(input logic v, input logic signed [IW-1:0] d);
      in_valid = v;
      data_in  = d;
      @(posedge clk);
      cyc++;
      if (rst_n && v) accept(d);
      #1;
      if (expq.size() > 0 && expq[0].due == cyc) begin
         chk("out_valid", out_valid, 1);
         chk("data_out", data_out, expq[0].d);
         chk("sat", sat, expq[0].s);
         last_d = data_out;
         last_s = sat;
         void'(expq.pop_front());
      end else chk("out_valid_idle", out_valid, 0);
      if (!rst_n) begin
         chk("rst_data_out", data_out, 0);
         chk("rst_sat", sat, 0);
      end
   endtask

   task automatic drain();
      repeat (N + 3) tick(1'b0, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", data_out, 0);
      chk("async_rst_sat", sat, 0);
      tick(1'b0, '0);
      tick(1'b0, '0);
      rst_n = 1'b1;
      L_m = clampL(int'(decim_log2));
   endtask

   initial begin
      cyc = 0;
      model_clear();
      #2;
      // DC step, R=16
      decim_log2 = 4'd4; gain = '0;
      do_reset();
      repeat (16*10) tick(1'b1, 12'sd100);
      drain();
      chk("dc_settled", last_d, 100);
      chk("dc_sat", last_s, 0);

      // Gain boost into both saturation rails
      gain = 8'd5;
      repeat (16*3) tick(1'b1, 12'sd100);
      drain();
      chk("sat_pos_data", last_d, 2047);
      chk("sat_pos_flag", last_s, 1);
      repeat (16*8) tick(1'b1, -12'sd100);
      drain();
      chk("sat_neg_data", last_d, -2048);
      chk("sat_neg_flag", last_s, 1);

      // Gappy input, R=4
      gain = '0; decim_log2 = 4'd2;
      do_reset();
      repeat (60) begin
         tick(1'b1, 12'sd100);
         tick(1'b0, '0);
         tick(1'b0, '0);
      end
      drain();
      chk("gappy_dc", last_d, 100);

      // Ratio change mid-frame 4 -> 3
      decim_log2 = 4'd4;
      do_reset();
      repeat (16*6 + 5) tick(1'b1, 12'sd100);
      decim_log2 = 4'd3;
      repeat (150) tick(1'b1, 12'sd100);
      drain();
      chk("ratio_change_dc", last_d, 100);

      // Randomised data and valid pattern, including a clamped ratio request of 0
      for (int t = 0; t < 3; t++) begin
         decim_log2 = (t == 0) ? 4'd0 : LW'(t + 1);
         gain = GW'($urandom_range(0, 6));
         do_reset();
         repeat (400) begin
            logic signed [IW-1:0] rd;
            rd = IW'($urandom);
            tick(logic'($urandom_range(0, 3) != 0), rd);
         end
         drain();
      end

      // Async reset with frames in the comb pipeline
      decim_log2 = 4'd2; gain = '0;
      do_reset();
      repeat (40) tick(1'b1, 12'sd50);
      chk("pre_reset_dc", last_d, 50);
      for (int i = 0; i < 20 && expq.size() == 0; i++) tick(1'b1, 12'sd50);
      tick(1'b1, 12'sd50);
      do_reset();
      repeat (12) tick(1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
